// File: rtl/sa_pkg.sv
// sa_pkg -- shared defaults and types for the systolic-array core.
//   SA_ROWS    : default array dimension (SA_ROWS x SA_ROWS PEs)
//   SA_DW      : default operand width
//   SA_ACCW    : default accumulator / result width
//   SA_FDEPTH  : default depth of each per-row result FIFO
//   sa_result_t: result word at the default accumulator width
//   sa_width() : index width for a count of n items (never below 1)
package sa_pkg;

    localparam int unsigned SA_ROWS   = 8;
    localparam int unsigned SA_DW     = 8;
    localparam int unsigned SA_ACCW   = 32;
    localparam int unsigned SA_FDEPTH = 2 * SA_ROWS;

    typedef logic [SA_ACCW-1:0] sa_result_t;

    function automatic int unsigned sa_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// sa_pe -- one processing element of the output-stationary array.
// Multiplies the operands arriving from the west (activation) and north (weight),
// accumulates while both carry a valid bit, and on the last beat of a tile emits the
// final sum with a one-cycle strobe while restarting the accumulator.
// Ports:
//   clk, rstn                   : clock, asynchronous active-low reset
//   a_west/a_vld_west/a_last_west : activation lane entering from the left
//   w_north/w_vld_north/w_last_north : weight lane entering from above
//   a_east/...                  : activation lane forwarded right, one cycle later
//   w_south/...                 : weight lane forwarded down, one cycle later
//   result, result_stb          : tile sum and its one-cycle strobe
module sa_pe
    import sa_pkg::*;
#(
    parameter int unsigned DW   = SA_DW,
    parameter int unsigned ACCW = SA_ACCW
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [DW-1:0]   a_west,
    input  logic            a_vld_west,
    input  logic            a_last_west,
    input  logic [DW-1:0]   w_north,
    input  logic            w_vld_north,
    input  logic            w_last_north,
    output logic [DW-1:0]   a_east,
    output logic            a_vld_east,
    output logic            a_last_east,
    output logic [DW-1:0]   w_south,
    output logic            w_vld_south,
    output logic            w_last_south,
    output logic [ACCW-1:0] result,
    output logic            result_stb
);

    logic [DW-1:0]   a_q, w_q;
    logic            a_vld_q, a_last_q, w_vld_q, w_last_q;
    logic [ACCW-1:0] acc_q, res_q;
    logic            stb_q;

    logic            beat, tile_end;
    logic [ACCW-1:0] prod, sum;

    // Both lanes are skewed to arrive together, so their valid/last bits agree.
    assign beat     = a_vld_west & w_vld_north;
    assign tile_end = beat & a_last_west & w_last_north;

    // Unsigned product, taken modulo 2^ACCW like the running sum.
    assign prod = ACCW'(a_west) * ACCW'(w_north);
    assign sum  = acc_q + prod;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q      <= '0;
            a_vld_q  <= 1'b0;
            a_last_q <= 1'b0;
            w_q      <= '0;
            w_vld_q  <= 1'b0;
            w_last_q <= 1'b0;
            acc_q    <= '0;
            res_q    <= '0;
            stb_q    <= 1'b0;
        end else begin
            a_q      <= a_west;
            a_vld_q  <= a_vld_west;
            a_last_q <= a_last_west;
            w_q      <= w_north;
            w_vld_q  <= w_vld_north;
            w_last_q <= w_last_north;
            stb_q    <= tile_end;
            if (beat) begin
                acc_q <= tile_end ? '0 : sum;
            end
            if (tile_end) begin
                res_q <= sum;
            end
        end
    end

    assign a_east       = a_q;
    assign a_vld_east   = a_vld_q;
    assign a_last_east  = a_last_q;
    assign w_south      = w_q;
    assign w_vld_south  = w_vld_q;
    assign w_last_south = w_last_q;
    assign result       = res_q;
    assign result_stb   = stb_q;

endmodule

// File: rtl/sa_core.sv
// sa_core -- ROWS x ROWS output-stationary systolic matrix-multiply core.
// Each accepted beat supplies one activation per row and one weight per column; a tile
// is ROWS accepted beats. PE(r,c) accumulates a[r]*w[c] over the tile and its sum is
// queued into the row r result FIFO, columns entering in order on consecutive cycles.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   ainport     : activation operand per row
//   winport     : weight operand per column
//   inpvalid    : operands valid this cycle (no back-pressure)
//   outread     : pop the head of every non-empty row FIFO
//   routport    : head of each row FIFO (0 when empty)
//   rvalidport  : row FIFO non-empty flags
module sa_core
    import sa_pkg::*;
#(
    parameter int unsigned ROWS   = SA_ROWS,
    parameter int unsigned DW     = SA_DW,
    parameter int unsigned ACCW   = SA_ACCW,
    parameter int unsigned FDEPTH = 2 * ROWS
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [DW-1:0]   ainport    [0:ROWS-1],
    input  logic [DW-1:0]   winport    [0:ROWS-1],
    input  logic            inpvalid,
    input  logic            outread,
    output logic [ACCW-1:0] routport   [0:ROWS-1],
    output logic [0:ROWS-1] rvalidport
);

    localparam int unsigned CNTW = sa_width(ROWS);
    localparam int unsigned PTRW = sa_width(FDEPTH);
    localparam int unsigned OCCW = $clog2(FDEPTH + 1);
    // Skew lane word: {last, valid, data}
    localparam int unsigned LW   = DW + 2;

    // ---------------------------------------------------------------- tile counter
    logic [CNTW-1:0] beat_cnt_q;
    logic            beat_last;

    assign beat_last = (beat_cnt_q == CNTW'(ROWS - 1));

    // Bubbles hold the count, so a partial tile resumes on the next accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_q <= '0;
        end else if (inpvalid) begin
            beat_cnt_q <= beat_last ? '0 : beat_cnt_q + CNTW'(1);
        end
    end

    // ---------------------------------------------------------------- input stage
    logic [DW-1:0] in_a_q [ROWS];
    logic [DW-1:0] in_w_q [ROWS];
    logic          in_vld_q, in_last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ROWS; i++) begin
                in_a_q[i] <= '0;
                in_w_q[i] <= '0;
            end
            in_vld_q  <= 1'b0;
            in_last_q <= 1'b0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                in_a_q[i] <= ainport[i];
                in_w_q[i] <= winport[i];
            end
            in_vld_q  <= inpvalid;
            in_last_q <= inpvalid & beat_last;
        end
    end

    // ---------------------------------------------------------------- array lanes
    // a_*[r][c] enters PE(r,c) from the left; w_*[r][c] enters PE(r,c) from above.
    logic [DW-1:0]   a_dat [ROWS][ROWS+1];
    logic            a_vld [ROWS][ROWS+1];
    logic            a_lst [ROWS][ROWS+1];
    logic [DW-1:0]   w_dat [ROWS+1][ROWS];
    logic            w_vld [ROWS+1][ROWS];
    logic            w_lst [ROWS+1][ROWS];
    logic [ACCW-1:0] pe_res [ROWS][ROWS];
    logic            pe_stb [ROWS][ROWS];

    // Row i activations and column i weights are delayed i cycles so that a beat
    // meets itself at PE(r,c) exactly r+c cycles after leaving the input stage.
    for (genvar i = 0; i < ROWS; i++) begin : g_skew
        logic [LW-1:0] a_entry, w_entry, a_tap, w_tap;

        assign a_entry = {in_last_q, in_vld_q, in_a_q[i]};
        assign w_entry = {in_last_q, in_vld_q, in_w_q[i]};

        if (i == 0) begin : g_direct
            assign a_tap = a_entry;
            assign w_tap = w_entry;
        end else begin : g_delay
            logic [i-1:0][LW-1:0] a_sr, w_sr;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    a_sr <= '0;
                    w_sr <= '0;
                end else begin
                    a_sr[0] <= a_entry;
                    w_sr[0] <= w_entry;
                    for (int k = 1; k < i; k++) begin
                        a_sr[k] <= a_sr[k-1];
                        w_sr[k] <= w_sr[k-1];
                    end
                end
            end

            assign a_tap = a_sr[i-1];
            assign w_tap = w_sr[i-1];
        end

        assign {a_lst[i][0], a_vld[i][0], a_dat[i][0]} = a_tap;
        assign {w_lst[0][i], w_vld[0][i], w_dat[0][i]} = w_tap;
    end

    // ---------------------------------------------------------------- PE grid
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < ROWS; c++) begin : g_col
            sa_pe #(
                .DW   (DW),
                .ACCW (ACCW)
            ) u_pe (
                .clk          (clk),
                .rstn         (rstn),
                .a_west       (a_dat[r][c]),
                .a_vld_west   (a_vld[r][c]),
                .a_last_west  (a_lst[r][c]),
                .w_north      (w_dat[r][c]),
                .w_vld_north  (w_vld[r][c]),
                .w_last_north (w_lst[r][c]),
                .a_east       (a_dat[r][c+1]),
                .a_vld_east   (a_vld[r][c+1]),
                .a_last_east  (a_lst[r][c+1]),
                .w_south      (w_dat[r+1][c]),
                .w_vld_south  (w_vld[r+1][c]),
                .w_last_south (w_lst[r+1][c]),
                .result       (pe_res[r][c]),
                .result_stb   (pe_stb[r][c])
            );
        end
    end

    // ---------------------------------------------------------------- row FIFOs
    for (genvar r = 0; r < ROWS; r++) begin : g_fifo
        logic [ACCW-1:0] push_data;
        logic            push;
        logic [ACCW-1:0] mem [FDEPTH];
        logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
        logic [OCCW-1:0] occ_q;
        logic            empty, full, do_push, do_pop;

        // Tiles are at least ROWS beats apart, so at most one column of a row
        // strobes in any cycle; the OR-style select never sees a collision.
        always_comb begin
            push      = 1'b0;
            push_data = '0;
            for (int c = 0; c < ROWS; c++) begin
                if (pe_stb[r][c]) begin
                    push      = 1'b1;
                    push_data = pe_res[r][c];
                end
            end
        end

        assign empty   = (occ_q == '0);
        assign full    = (occ_q == OCCW'(FDEPTH));
        assign do_pop  = outread & ~empty;
        // A full FIFO still takes a push when the same edge pops it.
        assign do_push = push & (~full | do_pop);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= (wr_ptr_q == PTRW'(FDEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
                end
                if (do_pop) begin
                    rd_ptr_q <= (rd_ptr_q == PTRW'(FDEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
                end
                if (do_push && !do_pop) begin
                    occ_q <= occ_q + OCCW'(1);
                end else if (do_pop && !do_push) begin
                    occ_q <= occ_q - OCCW'(1);
                end
            end
        end

        // Storage needs no reset: an empty FIFO masks its head to zero.
        always_ff @(posedge clk) begin
            if (do_push) begin
                mem[wr_ptr_q] <= push_data;
            end
        end

        assign routport[r]   = empty ? '0 : mem[rd_ptr_q];
        assign rvalidport[r] = ~empty;
    end

endmodule

// File: tb/tb_sa_core.sv
// tb_sa_core -- directed scoreboard bench for sa_core (8x8, 8-bit operands), with a
// second 16-bit-accumulator instance sharing the same stimulus to observe wrap-around.
module tb_sa_core;
    import sa_pkg::*;

    localparam int unsigned ROWS = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  ainport  [0:ROWS-1];
    logic [7:0]  winport  [0:ROWS-1];
    logic        inpvalid;
    logic        outread;
    logic [31:0] routport   [0:ROWS-1];
    logic [0:ROWS-1] rvalidport;
    logic [15:0] routport16 [0:ROWS-1];
    logic [0:ROWS-1] rvalidport16;

    always #5 clk = ~clk;

    sa_core #(.ROWS(8), .DW(8), .ACCW(32), .FDEPTH(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ainport    (ainport),
        .winport    (winport),
        .inpvalid   (inpvalid),
        .outread    (outread),
        .routport   (routport),
        .rvalidport (rvalidport)
    );

    sa_core #(.ROWS(8), .DW(8), .ACCW(16), .FDEPTH(16)) dut16 (
        .clk        (clk),
        .rstn       (rstn),
        .ainport    (ainport),
        .winport    (winport),
        .inpvalid   (inpvalid),
        .outread    (outread),
        .routport   (routport16),
        .rvalidport (rvalidport16)
    );

    typedef struct {
        int         row;
        sa_result_t val;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t0 = 0;
    logic [7:0] ta [8][8];   // [beat][row]
    logic [7:0] tw [8][8];   // [beat][column]

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: a=1 w=2; 1: a=r+1 w=c+1; 2: all 255; 3: random
    task automatic make_tile(input int mode);
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                case (mode)
                    0: begin ta[b][i] = 8'd1; tw[b][i] = 8'd2; end
                    1: begin ta[b][i] = 8'(i + 1); tw[b][i] = 8'(i + 1); end
                    2: begin ta[b][i] = 8'd255; tw[b][i] = 8'd255; end
                    default: begin
                        ta[b][i] = 8'($urandom_range(0, 255));
                        tw[b][i] = 8'($urandom_range(0, 255));
                    end
                endcase
            end
        end
    endtask

    task automatic push_expected();
        sa_result_t sum;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                sum = '0;
                for (int b = 0; b < 8; b++) begin
                    sum = sum + 32'(ta[b][r]) * 32'(tw[b][c]);
                end
                sb.push_back('{row: r, val: sum});
            end
        end
    endtask

    // Drives nbeats beats of the current tile; with gaps, each beat is followed by
    // a bubble carrying random operands that must not be accumulated.
    task automatic drive_tile(input bit gaps, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            inpvalid = 1'b1;
            for (int i = 0; i < 8; i++) begin
                ainport[i] = ta[b][i];
                winport[i] = tw[b][i];
            end
            if (b == 0) t0 = cyc + 1;
            if (gaps) begin
                @(negedge clk);
                inpvalid = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    ainport[i] = 8'($urandom_range(0, 255));
                    winport[i] = 8'($urandom_range(0, 255));
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            inpvalid = 1'b0;
        end
    endtask

    function automatic int find_row(input int r);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].row == r) return i;
        end
        return -1;
    endfunction

    // Pops results with outread held high, comparing each against the scoreboard.
    task automatic drain(input bit timing);
        int seen[8];
        int budget;
        int idx;
        for (int r = 0; r < 8; r++) seen[r] = -1;
        budget = 0;
        while (sb.size() > 0 && budget < 300) begin
            @(negedge clk);
            inpvalid = 1'b0;
            outread  = 1'b1;
            budget++;
            for (int r = 0; r < 8; r++) begin
                if (rvalidport[r]) begin
                    if (seen[r] < 0) seen[r] = cyc;
                    idx = find_row(r);
                    if (idx < 0) begin
                        chk($sformatf("row%0d_unexpected_valid", r), {31'b0, rvalidport[r]}, 32'd0);
                    end else begin
                        chk($sformatf("row%0d_result", r), routport[r], sb[idx].val);
                        chk($sformatf("row%0d_result16", r), {16'b0, routport16[r]},
                            {16'b0, sb[idx].val[15:0]});
                        chk($sformatf("row%0d_valid16", r), {31'b0, rvalidport16[r]}, 32'd1);
                        sb.delete(idx);
                    end
                end
            end
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk("drained_rvalid", {24'b0, rvalidport}, 32'd0);
        chk("drained_rvalid16", {24'b0, rvalidport16}, 32'd0);
        outread = 1'b0;
        if (timing) begin
            for (int r = 0; r < 8; r++) begin
                chk($sformatf("row%0d_first_valid_cycle", r), 32'(seen[r]), 32'(t0 + 9 + r));
            end
        end
    endtask

    initial begin
        rstn     = 1'b0;
        inpvalid = 1'b0;
        outread  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ainport[i] = '0;
            winport[i] = '0;
        end
        #1;
        for (int r = 0; r < 8; r++) chk($sformatf("reset_rout%0d", r), routport[r], 32'd0);
        chk("reset_rvalid", {24'b0, rvalidport}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // All ones times twos, with arrival timing of each row's first result.
        make_tile(0); push_expected(); drive_tile(1'b0, 8); drain(1'b1);

        // Row/column ramp, contiguous then with bubbles between beats.
        make_tile(1); push_expected(); drive_tile(1'b0, 8); drain(1'b0);
        make_tile(1); push_expected(); drive_tile(1'b1, 8); drain(1'b0);

        // Random operands.
        make_tile(3); push_expected(); drive_tile(1'b0, 8); drain(1'b0);

        // Maximum operands: 520200, wrapping to 61448 in the 16-bit instance.
        make_tile(2); push_expected(); drive_tile(1'b0, 8); drain(1'b0);

        // Three tiles without reading: two fill each FIFO, the third is dropped.
        make_tile(1); push_expected(); drive_tile(1'b0, 8);
        make_tile(3); push_expected(); drive_tile(1'b0, 8);
        make_tile(0);                  drive_tile(1'b0, 8);
        idle(24);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_rvalid_all_ones", {24'b0, rvalidport}, 32'hFF);
        end
        drain(1'b0);

        // Reset mid-tile with results queued: outputs clear before any clock edge.
        make_tile(3); push_expected(); drive_tile(1'b0, 8);
        idle(20);
        make_tile(0); drive_tile(1'b0, 4);
        @(negedge clk);
        inpvalid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        for (int r = 0; r < 8; r++) chk($sformatf("async_reset_rout%0d", r), routport[r], 32'd0);
        chk("async_reset_rvalid", {24'b0, rvalidport}, 32'd0);
        chk("async_reset_rvalid16", {24'b0, rvalidport16}, 32'd0);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        make_tile(3); push_expected(); drive_tile(1'b0, 8); drain(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sa_core.md
SA_CORE -- requirements
Module: sa_core

Interface
REQ-001 SHALL have parameter ROWS, default 8, giving the array dimension (ROWS x ROWS PEs) and the port vector count.
REQ-002 SHALL have parameter DW, default 8, giving the operand width.
REQ-003 SHALL have parameter ACCW, default 32, giving the accumulator and result width.
REQ-004 SHALL have parameter FDEPTH, default 2*ROWS, giving the depth of each per-row result FIFO.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port ainport  input  ROWS x DW  activation operand per row, unpacked array [0:ROWS-1].
REQ-008 SHALL have port winport  input  ROWS x DW  weight operand per column, unpacked array [0:ROWS-1].
REQ-009 SHALL have port inpvalid  input  1  ainport/winport hold a valid beat this cycle; there is no back-pressure.
REQ-010 SHALL have port outread  input  1  pop the head of every row FIFO that is non-empty.
REQ-011 SHALL have port routport  output  ROWS x ACCW  head-of-FIFO result per row, unpacked array [0:ROWS-1].
REQ-012 SHALL have port rvalidport  output  ROWS  packed [0:ROWS-1]; bit r high when row r FIFO is non-empty.

Function
REQ-013 SHALL be an output-stationary array: PE(r,c) accumulates ainport[r] x winport[c] over one tile.
REQ-014 SHALL treat products and sums as unsigned; products SHALL be zero-extended to ACCW.
REQ-015 SHALL let accumulation wrap modulo 2^ACCW, with no saturation.
REQ-016 SHALL define a tile as ROWS accepted beats (inpvalid=1), counted by an internal beat counter 0..ROWS-1 that wraps.
REQ-017 SHALL internally skew inputs: row r operand delayed r cycles, column c operand delayed c cycles.
REQ-018 SHALL move data systolically: a moves right, w moves down, one PE per cycle, each carrying a valid bit and a last-of-tile bit.
REQ-019 SHALL make a beat accepted at edge T accumulate in PE(r,c) at edge T+1+r+c.
REQ-020 SHALL make cycles with inpvalid=0 bubbles: no accumulation, tile count held, so a partial tile resumes on later beats.
REQ-021 SHALL, on the last beat of a tile at PE(r,c), copy the final sum (including that product) as a result and restart the accumulator from the next beat.
REQ-022 SHALL push each such result into row r FIFO at edge T+2+r+c; row r results therefore enter in column order 0..ROWS-1 on consecutive cycles.
REQ-023 SHALL drive routport[r] from the row r FIFO head and rvalidport[r] = FIFO non-empty, with no combinational path from inputs.
REQ-024 SHALL make outread=1 pop every non-empty row at the edge; outread to an empty row has no effect.
REQ-025 SHALL allow a push and a pop in the same cycle on one FIFO, leaving occupancy unchanged.
REQ-026 SHALL drop a result pushed into a full FIFO (no pop that cycle); other rows are unaffected.
REQ-027 SHALL hold routport[r] at 0 while row r is empty.

Reset
REQ-028 SHALL, while rstn=0, clear all accumulators, skew and pipeline registers, valid/last bits, the beat counter and FIFO pointers.
REQ-029 SHALL hold routport=0 and rvalidport=0 while rstn=0.
REQ-030 SHALL discard an in-flight tile on reset mid-operation; the first beat after release starts a new tile.

Structure
REQ-031 SHALL place ROWS, DW, ACCW and FDEPTH defaults, plus the result typedef, in a shared package sa_pkg.
REQ-032 SHALL use one sub-module, sa_pe: MAC, a/w/valid/last forwarding registers, and a result-out strobe.
REQ-033 SHALL implement the per-row FIFOs and skew registers inline in sa_core.

Verification
REQ-034 SHALL cover: reset, then 8 beats of all a=1, w=2 -> all 64 results = 16; row r column 0 result valid at edge T0+7+2+r.
REQ-035 SHALL cover: a[r]=r+1, w[c]=c+1, constant for 8 beats -> row r FIFO yields 8*(r+1)*(c+1) for c=0..7, in column order.
REQ-036 SHALL cover: 8 beats with inpvalid toggling 1/0 -> results identical to the contiguous case, delayed; bubbles not accumulated.
REQ-037 SHALL cover: a=w=255 over 8 beats -> 520200 each; with ACCW=16, result = 520200 mod 65536 = 61448.
REQ-038 SHALL cover: 3 tiles with outread=0 -> each row holds 16 results and drops the 3rd tile; rvalidport stays all ones until drained.
REQ-039 SHALL cover: rstn pulsed low mid-tile -> outputs 0 immediately (asynchronous), and the next full tile gives clean sums.
